// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage RV32IC pipeline.
// Drives the PC and every pipeline-register Stall/Flush from the current state
// and the hazard inputs with zero latency. It remembers a redirect that arrived
// while an I-miss was pending, and it runs a sticky watchdog on long D-mem waits.
// Optional macro PIPE_HAZARD_PERF_EN builds the stall/flush performance counters.
// When the macro is not defined, both counter outputs are tied to 0.
module pipe_hazard_ctrl #(
    parameter int RESET_FLUSH_CYCLES = 2,
    parameter int DMEM_TIMEOUT       = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  ifid_rs1_addr,
    input  logic [4:0]  ifid_rs2_addr,
    input  logic        ifid_uses_rs1,
    input  logic        ifid_uses_rs2,
    input  logic        idex_memread,
    input  logic [4:0]  idex_rdaddr,
    input  logic        ex_mispredict,
    input  logic        icache_stall,
    input  logic        dcache_stall,
    output logic        pc_stall_o,
    output logic        redirect_replay_o,
    output logic        ifid_stall_o,
    output logic        ifid_flush_o,
    output logic        idex_stall_o,
    output logic        idex_flush_o,
    output logic        exmem_stall_o,
    output logic        memwb_stall_o,
    output logic        mem_timeout_o,
    output logic [31:0] stall_cycles_o,
    output logic [31:0] flush_events_o
);

    typedef enum logic [2:0] {
        ST_INIT, ST_RUN, ST_DWAIT, ST_DWAIT_I, ST_IWAIT, ST_IWAIT_KILL
    } state_t;

    localparam logic [15:0] INIT_LOAD   = 16'(RESET_FLUSH_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_VAL = 16'(DMEM_TIMEOUT);

    state_t      state_reg, state_next;
    logic [15:0] init_cnt_reg, init_cnt_next;
    logic [15:0] wdog_reg, wdog_next;
    logic        timeout_reg, timeout_next;

    logic loaduse;
    logic freeze_mode;
    logic iwait_like;

    assign loaduse = idex_memread && (idex_rdaddr != 5'd0) &&
                     ((ifid_uses_rs1 && (ifid_rs1_addr == idex_rdaddr)) ||
                      (ifid_uses_rs2 && (ifid_rs2_addr == idex_rdaddr)));

    // A D-wait state that still has the cache stalled keeps the whole pipe frozen.
    assign freeze_mode = ((state_reg == ST_DWAIT) || (state_reg == ST_DWAIT_I)) && dcache_stall;

    // A D-wait that is leaving during an I-miss falls straight into the I-wait rules.
    // Both the I-wait state and that D-wait case behave as an I-wait while the I-miss holds.
    assign iwait_like = ((state_reg == ST_IWAIT) ||
                         ((state_reg == ST_DWAIT_I) && !dcache_stall)) && icache_stall;

    assign mem_timeout_o = timeout_reg;

    // State register with init counter, D-mem watchdog and sticky timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_INIT;
            init_cnt_reg <= INIT_LOAD;
            wdog_reg     <= 16'd0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            init_cnt_reg <= init_cnt_next;
            wdog_reg     <= wdog_next;
            timeout_reg  <= timeout_next;
        end
    end

    // Next-state selection. Any state that is leaving a wait re-evaluates the RUN priority in the same cycle.
    always_comb begin
        state_next    = state_reg;
        init_cnt_next = init_cnt_reg;
        wdog_next     = 16'd0;
        timeout_next  = timeout_reg;
        if (state_reg == ST_INIT) begin
            if (init_cnt_reg == 16'd0) state_next = ST_RUN;
            else                       init_cnt_next = init_cnt_reg - 16'd1;
        end else if (freeze_mode) begin
            if (wdog_reg != TIMEOUT_VAL) wdog_next = wdog_reg + 16'd1;
            else                         wdog_next = wdog_reg;
            if ((wdog_reg + 16'd1) >= TIMEOUT_VAL) timeout_next = 1'b1;
        end else if (state_reg == ST_IWAIT_KILL) begin
            if (!dcache_stall && !icache_stall) state_next = ST_RUN;
        end else if (iwait_like) begin
            if (dcache_stall)       state_next = ST_DWAIT_I;
            else if (ex_mispredict) state_next = ST_IWAIT_KILL;
            else                    state_next = ST_IWAIT;
        end else begin
            if (dcache_stall)       state_next = ST_DWAIT;
            else if (ex_mispredict) state_next = icache_stall ? ST_IWAIT_KILL : ST_RUN;
            else if (loaduse)       state_next = ST_RUN;
            else if (icache_stall)  state_next = ST_IWAIT;
            else                    state_next = ST_RUN;
        end
    end

    // Stall/flush outputs, combinational from state and hazard inputs
    always_comb begin
        pc_stall_o        = 1'b0;
        redirect_replay_o = 1'b0;
        ifid_stall_o      = 1'b0;
        ifid_flush_o      = 1'b0;
        idex_stall_o      = 1'b0;
        idex_flush_o      = 1'b0;
        exmem_stall_o     = 1'b0;
        memwb_stall_o     = 1'b0;
        if (state_reg == ST_INIT) begin
            pc_stall_o   = 1'b1;
            ifid_flush_o = 1'b1;
            idex_flush_o = 1'b1;
        end else if (freeze_mode || dcache_stall) begin
            // A D-mem stall dominates every other event in every running state.
            pc_stall_o    = 1'b1;
            ifid_stall_o  = 1'b1;
            idex_stall_o  = 1'b1;
            exmem_stall_o = 1'b1;
            memwb_stall_o = 1'b1;
        end else if (state_reg == ST_IWAIT_KILL) begin
            ifid_flush_o = 1'b1;
            if (icache_stall) pc_stall_o = 1'b1;
            else              redirect_replay_o = 1'b1;
        end else if (iwait_like) begin
            pc_stall_o = 1'b1;
            if (ex_mispredict) begin
                ifid_flush_o = 1'b1;
                idex_flush_o = 1'b1;
            end else if (loaduse) begin
                ifid_stall_o = 1'b1;
                idex_flush_o = 1'b1;
            end else begin
                ifid_flush_o = 1'b1;
            end
        end else begin
            if (ex_mispredict) begin
                ifid_flush_o = 1'b1;
                idex_flush_o = 1'b1;
                pc_stall_o   = icache_stall;
            end else if (loaduse) begin
                pc_stall_o   = 1'b1;
                ifid_stall_o = 1'b1;
                idex_flush_o = 1'b1;
            end else if (icache_stall) begin
                pc_stall_o   = 1'b1;
                ifid_flush_o = 1'b1;
            end
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] stall_cnt_reg;
    logic [31:0] flush_cnt_reg;

    // Saturating performance counters. Cycles spent in the post-reset flush are not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= 32'd0;
            flush_cnt_reg <= 32'd0;
        end else if (state_reg != ST_INIT) begin
            if (pc_stall_o && (stall_cnt_reg != 32'hFFFF_FFFF))
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            if ((ifid_flush_o || idex_flush_o) && (flush_cnt_reg != 32'hFFFF_FFFF))
                flush_cnt_reg <= flush_cnt_reg + 32'd1;
        end
    end

    assign stall_cycles_o = stall_cnt_reg;
    assign flush_events_o = flush_cnt_reg;
`else
    assign stall_cycles_o = 32'd0;
    assign flush_events_o = 32'd0;
`endif

endmodule
